// File: rtl/calc_pkg.sv
// Address and data width helpers shared by the command-layer sub-commands.
package calc_pkg;

  function automatic int num_column_address_bits(input int pixel_width);
    return (pixel_width > 1) ? $clog2(pixel_width) : 1;
  endfunction

  function automatic int num_row_address_bits(input int pixel_height);
    return (pixel_height > 1) ? $clog2(pixel_height) : 1;
  endfunction

  function automatic int num_pixelcolorselect_bits(input int bytes_per_pixel);
    return (bytes_per_pixel > 1) ? $clog2(bytes_per_pixel) : 1;
  endfunction

  function automatic int num_data_a_bits();
    return 8;
  endfunction

endpackage

// File: rtl/params.sv
// Panel geometry shared by the frame-buffer command layer.
package params;
  localparam int PIXEL_WIDTH     = 12;
  localparam int PIXEL_HEIGHT    = 6;
  localparam int BYTES_PER_PIXEL = 3;
endpackage

// File: rtl/patternfill_pkg.sv
// Types for the pattern-fill sub-command: FSM states and fill patterns.
package patternfill_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SOLID   = 2'd0,
    CHECKER = 2'd1,
    HSTRIPE = 2'd2,
    VSTRIPE = 2'd3
  } mode_e;

endpackage

// File: rtl/patternfill_color_sel.sv
// Combinational byte selector: picks primary/secondary colour from the pattern
// and the address, then returns byte `pixel`. Used only with CONTROL_PATTERNFILL_PATTERN_EN.
module patternfill_color_sel
  import patternfill_pkg::*;
#(
  parameter int RW    = 3,
  parameter int CW    = 4,
  parameter int PW    = 2,
  parameter int CLR_W = 24
) (
  input  mode_e            mode,
  input  logic [RW-1:0]    row,
  input  logic [CW-1:0]    column,
  input  logic [PW-1:0]    pixel,
  input  logic [CLR_W-1:0] color,
  input  logic [CLR_W-1:0] color_alt,
  output logic [7:0]       data
);

  logic             use_alt;
  logic [CLR_W-1:0] sel;
  logic             unused_hi;

  // Only the address parity matters to every pattern.
  assign unused_hi = ^{row[RW-1:1], column[CW-1:1]};

  always_comb begin
    use_alt = 1'b0;
    unique case (mode)
      SOLID:   use_alt = 1'b0;
      CHECKER: use_alt = row[0] ^ column[0];
      HSTRIPE: use_alt = row[0];
      VSTRIPE: use_alt = column[0];
      default: use_alt = 1'b0;
    endcase
    sel  = use_alt ? color_alt : color;
    data = 8'(sel >> {pixel, 3'b000});
  end

endmodule

// File: rtl/control_subcmd_patternfill.sv
// Clipped rectangle fill, one byte per clock, rows bottom-up. Patterns from
// color/color_alt are enabled by defining CONTROL_PATTERNFILL_PATTERN_EN.
module control_subcmd_patternfill
  import calc_pkg::*;
  import patternfill_pkg::*;
#(
  parameter int BYTES_PER_PIXEL = params::BYTES_PER_PIXEL,
  parameter int PIXEL_HEIGHT    = params::PIXEL_HEIGHT,
  parameter int PIXEL_WIDTH     = params::PIXEL_WIDTH,
  parameter int _UNUSED         = 0,
  localparam int CW    = num_column_address_bits(PIXEL_WIDTH),
  localparam int RW    = num_row_address_bits(PIXEL_HEIGHT),
  localparam int PW    = num_pixelcolorselect_bits(BYTES_PER_PIXEL),
  localparam int DW    = num_data_a_bits(),
  localparam int CLR_W = BYTES_PER_PIXEL * 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             ack,
  input  logic [CW-1:0]    x1,
  input  logic [RW-1:0]    y1,
  input  logic [CW-1:0]    width,
  input  logic [RW-1:0]    height,
  input  logic [CLR_W-1:0] color,
  input  logic [CLR_W-1:0] color_alt,
  input  logic [1:0]       mode,
  output logic [RW-1:0]    row,
  output logic [CW-1:0]    column,
  output logic [PW-1:0]    pixel,
  output logic [DW-1:0]    data_out,
  output logic             ram_write_enable,
  output logic             ram_access_start,
  output logic             done,
  output state_e           dbg_state
);

  localparam logic [CW:0]   X_MAX    = (CW+1)'(PIXEL_WIDTH);
  localparam logic [RW:0]   Y_MAX    = (RW+1)'(PIXEL_HEIGHT);
  localparam logic [PW-1:0] PIX_LAST = PW'(BYTES_PER_PIXEL - 1);

  state_e           state, state_n;
  logic             enable_q, latch, nz_in, nz_q;
  logic [CW:0]      x_sum, x_end_in, x_end_q, xe_m1;
  logic [RW:0]      y_sum, y_end_in, y_end_q, ye_m1;
  logic [CW-1:0]    x1_q, col_n;
  logic [RW-1:0]    y1_q, row_n;
  logic [PW-1:0]    pix_n;
  logic [CLR_W-1:0] color_q;
  logic [DW-1:0]    sel_byte;
  logic             we_n, start_n, done_n;

  assign dbg_state = state;

  // End coordinates are one bit wider so origin+size never wraps before clipping.
  always_comb begin
    x_sum    = {1'b0, x1} + {1'b0, width};
    y_sum    = {1'b0, y1} + {1'b0, height};
    x_end_in = (x_sum > X_MAX) ? X_MAX : x_sum;
    y_end_in = (y_sum > Y_MAX) ? Y_MAX : y_sum;
    nz_in    = ({1'b0, x1} < x_end_in) && ({1'b0, y1} < y_end_in);
    xe_m1    = x_end_q - (CW+1)'(1);
    ye_m1    = y_end_q - (RW+1)'(1);
  end

  always_comb begin
    state_n = state;
    row_n   = row;
    col_n   = column;
    pix_n   = pixel;
    we_n    = 1'b0;
    start_n = 1'b0;
    done_n  = 1'b0;
    latch   = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && !enable_q) begin
          state_n = SETUP;
          latch   = 1'b1;
          start_n = nz_in;
        end
      end
      SETUP: begin
        if (nz_q) begin
          state_n = WRITE;
          row_n   = ye_m1[RW-1:0];
          col_n   = x1_q;
          pix_n   = '0;
          we_n    = 1'b1;
        end else begin
          state_n = DONE;
          done_n  = 1'b1;
        end
      end
      WRITE: begin
        we_n = 1'b1;
        if (pixel != PIX_LAST) begin
          pix_n = pixel + PW'(1);
        end else if ({1'b0, column} != xe_m1) begin
          pix_n = '0;
          col_n = column + CW'(1);
        end else if (row != y1_q) begin
          pix_n = '0;
          col_n = x1_q;
          row_n = row - RW'(1);
        end else begin
          state_n = DONE;
          done_n  = 1'b1;
          we_n    = 1'b0;
        end
      end
      DONE: begin
        if (ack) state_n = IDLE;
        else     done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef CONTROL_PATTERNFILL_PATTERN_EN
  logic [CLR_W-1:0] color_alt_q;
  mode_e            mode_q;
  logic             unused_ok;

  assign unused_ok = 1'(_UNUSED);

  patternfill_color_sel #(
    .RW(RW), .CW(CW), .PW(PW), .CLR_W(CLR_W)
  ) u_color_sel (
    .mode      (mode_q),
    .row       (row_n),
    .column    (col_n),
    .pixel     (pix_n),
    .color     (color_q),
    .color_alt (color_alt_q),
    .data      (sel_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      color_alt_q <= '0;
      mode_q      <= SOLID;
    end else if (latch) begin
      color_alt_q <= color_alt;
      mode_q      <= mode_e'(mode);
    end
  end
`else
  logic unused_ok;

  assign unused_ok = ^{mode, color_alt, 1'(_UNUSED)};
  assign sel_byte  = DW'(color_q >> {pix_n, 3'b000});
`endif

  // Data is looked up from the next address so it is registered alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      enable_q         <= 1'b0;
      nz_q             <= 1'b0;
      x1_q             <= '0;
      y1_q             <= '0;
      x_end_q          <= '0;
      y_end_q          <= '0;
      color_q          <= '0;
      row              <= '0;
      column           <= '0;
      pixel            <= '0;
      data_out         <= '0;
      ram_write_enable <= 1'b0;
      ram_access_start <= 1'b0;
      done             <= 1'b0;
    end else begin
      state            <= state_n;
      enable_q         <= enable;
      row              <= row_n;
      column           <= col_n;
      pixel            <= pix_n;
      data_out         <= sel_byte;
      ram_write_enable <= we_n;
      ram_access_start <= start_n;
      done             <= done_n;
      if (latch) begin
        nz_q    <= nz_in;
        x1_q    <= x1;
        y1_q    <= y1;
        x_end_q <= x_end_in;
        y_end_q <= y_end_in;
        color_q <= color;
      end
    end
  end

endmodule

// File: tb/tb_control_subcmd_patternfill.sv
// Bench for control_subcmd_patternfill: table of fills, random fills, and
// hand-written enable/reset sequences against a loop-based rectangle model.
module tb_control_subcmd_patternfill;
  import calc_pkg::*;
  import patternfill_pkg::*;

  localparam int W     = params::PIXEL_WIDTH;
  localparam int H     = params::PIXEL_HEIGHT;
  localparam int BPP   = params::BYTES_PER_PIXEL;
  localparam int CW    = num_column_address_bits(W);
  localparam int RW    = num_row_address_bits(H);
  localparam int PW    = num_pixelcolorselect_bits(BPP);
  localparam int CLR_W = BPP * 8;
  localparam int EW    = RW + CW + PW + 8;

  logic             clk = 1'b0;
  logic             reset, enable, ack;
  logic [CW-1:0]    x1, width;
  logic [RW-1:0]    y1, height;
  logic [CLR_W-1:0] color, color_alt;
  logic [1:0]       mode;
  logic [RW-1:0]    row;
  logic [CW-1:0]    column;
  logic [PW-1:0]    pixel;
  logic [7:0]       data_out;
  logic             ram_write_enable, ram_access_start, done;
  state_e           dbg_state;

  always #5 clk = ~clk;

  control_subcmd_patternfill dut (
    .clk(clk), .reset(reset), .enable(enable), .ack(ack),
    .x1(x1), .y1(y1), .width(width), .height(height),
    .color(color), .color_alt(color_alt), .mode(mode),
    .row(row), .column(column), .pixel(pixel), .data_out(data_out),
    .ram_write_enable(ram_write_enable), .ram_access_start(ram_access_start),
    .done(done), .dbg_state(dbg_state)
  );

  typedef struct {
    int               x1, y1, w, h;
    logic [CLR_W-1:0] color, alt;
    int               mode;
    int               exp_writes;
  } vec_t;

  vec_t           vecs[11];
  logic [EW-1:0]  exp_q[$];
  int             tests_run = 0;
  int             tests_failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input int r, input int c, input int p,
                                            input int m, input logic [CLR_W-1:0] col,
                                            input logic [CLR_W-1:0] alt);
    logic [CLR_W-1:0] s;
    bit use_alt;
    use_alt = 0;
`ifdef CONTROL_PATTERNFILL_PATTERN_EN
    case (m)
      1: use_alt = ((r + c) % 2) == 1;
      2: use_alt = (r % 2) == 1;
      3: use_alt = (c % 2) == 1;
      default: use_alt = 0;
    endcase
`endif
    s = use_alt ? alt : col;
    return s[p*8 +: 8];
  endfunction

  // Expected write stream: bottom row first, left to right, bytes in order.
  function automatic int build_model(input vec_t v);
    int xe, ye, n;
    xe = (v.x1 + v.w < W) ? v.x1 + v.w : W;
    ye = (v.y1 + v.h < H) ? v.y1 + v.h : H;
    n = 0;
    exp_q.delete();
    for (int r = ye - 1; r >= v.y1; r--)
      for (int c = v.x1; c < xe; c++)
        for (int p = 0; p < BPP; p++) begin
          exp_q.push_back({RW'(r), CW'(c), PW'(p), model_byte(r, c, p, v.mode, v.color, v.alt)});
          n++;
        end
    return n;
  endfunction

  task automatic do_fill(input vec_t v, input bit hold_en, input bit rand_ack, output int writes);
    int  n, cyc, starts;
    bit  saw_done;
    n = build_model(v);
    x1 = CW'(v.x1); y1 = RW'(v.y1); width = CW'(v.w); height = RW'(v.h);
    color = v.color; color_alt = v.alt; mode = 2'(v.mode);
    enable = 1'b1;
    @(posedge clk); #1;
    check("start_pulse", ram_access_start, (n != 0));
    check("state_setup", dbg_state, SETUP);
    if (!hold_en) enable = 1'b0;
    x1 = CW'($urandom); y1 = RW'($urandom); width = CW'($urandom); height = RW'($urandom);
    color = CLR_W'($urandom); color_alt = CLR_W'($urandom); mode = 2'($urandom);
    writes = 0; cyc = 0; starts = 0; saw_done = 0;
    while (!saw_done && cyc < 1000) begin
      if (rand_ack) ack = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
      if (ram_access_start) starts++;
      if (ram_write_enable) begin
        writes++;
        if (exp_q.size() == 0) begin
          tests_run++; tests_failed++;
          $display("FAIL extra_write: got r%0d c%0d p%0d expected no write", row, column, pixel);
        end else begin
          check("write", {row, column, pixel, data_out}, exp_q.pop_front());
        end
      end
      if (done) saw_done = 1;
    end
    ack = 1'b0;
    check("done_seen", saw_done, 1);
    check("done_latency", cyc, n + 1);
    check("write_count", writes, n);
    check("extra_start", starts, 0);
    repeat (2) @(posedge clk);
    #1 check("done_hold", done, 1);
    ack = 1'b1;
    @(posedge clk); #1;
    check("ack_done_low", done, 0);
    check("ack_to_idle", dbg_state, IDLE);
    ack = 1'b0;
  endtask

  initial begin
    int   wr, cnt;
    vec_t v;
    vecs[0]  = '{0, 0, 12, 6, 24'h000000, 24'h000000, 0, 216};
    vecs[1]  = '{0, 0, 12, 6, 24'hA5A5A5, 24'h5A5A5A, 1, 216};
    vecs[2]  = '{10, 3, 8, 7, 24'h112233, 24'h445566, 2, 18};
    vecs[3]  = '{2, 1, 0, 5, 24'hFFFFFF, 24'h000000, 0, 0};
    vecs[4]  = '{3, 0, 4, 0, 24'hFFFFFF, 24'h000000, 0, 0};
    vecs[5]  = '{12, 0, 3, 3, 24'h123456, 24'h654321, 1, 0};
    vecs[6]  = '{0, 6, 5, 1, 24'h123456, 24'h654321, 2, 0};
    vecs[7]  = '{5, 2, 1, 1, 24'hC0FFEE, 24'hBADBAD, 3, 3};
    vecs[8]  = '{4, 1, 5, 3, 24'h0A0B0C, 24'hD0E0F0, 3, 45};
    vecs[9]  = '{11, 5, 15, 7, 24'h778899, 24'h112233, 1, 3};
    vecs[10] = '{0, 0, 15, 7, 24'h010203, 24'h040506, 1, 216};

    reset = 1'b1; enable = 1'b0; ack = 1'b0;
    x1 = '0; y1 = '0; width = '0; height = '0; color = '0; color_alt = '0; mode = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {row, column, pixel, data_out, ram_write_enable, ram_access_start, done}, 0);
    check("reset_state", dbg_state, IDLE);
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      do_fill(vecs[i], 1'b0, 1'b0, wr);
      check("table_count", wr, vecs[i].exp_writes);
    end

    for (int i = 0; i < 25; i++) begin
      v.x1 = $urandom_range(0, 15); v.y1 = $urandom_range(0, 7);
      v.w  = $urandom_range(0, 15); v.h  = $urandom_range(0, 7);
      v.color = CLR_W'($urandom); v.alt = CLR_W'($urandom);
      v.mode = $urandom_range(0, 3); v.exp_writes = 0;
      do_fill(v, 1'b0, 1'b1, wr);
    end

    // Enable held high past the ack must not start another fill.
    do_fill(vecs[7], 1'b1, 1'b0, wr);
    cnt = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (ram_write_enable || ram_access_start || dbg_state != IDLE) cnt++;
    end
    check("held_enable_no_refire", cnt, 0);
    enable = 1'b0;
    @(posedge clk); #1;
    do_fill(vecs[8], 1'b0, 1'b0, wr);
    check("second_fill_count", wr, 45);

    // Reset in the middle of a write burst.
    x1 = 0; y1 = 0; width = 12; height = 6; color = 24'h5555AA; mode = 0;
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (6) @(posedge clk);
    #1 check("mid_write_active", ram_write_enable, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_reset_outputs", {row, column, pixel, data_out, ram_write_enable, ram_access_start, done}, 0);
    check("mid_reset_state", dbg_state, IDLE);
    reset = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ram_write_enable || ram_access_start) cnt++;
    end
    check("post_reset_writes", cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
